// File: rtl/dffn_chain_loader.sv
// Serial loader for a negative-edge flop chain: shifts a word in MSB first while
// capturing the chain's previous contents from its tail, then strobes LOAD and DONE.
module dffn_chain_loader #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             START,
    input  logic [WIDTH-1:0] DIN,
    input  logic             SO,
    output logic             SI,
    output logic             SEN,
    output logic             LOAD,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DOUT
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE,
        FIN
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    so_idx;

    // Tail sample taken at the end of shift cycle cnt lands at DOUT[WIDTH-2-cnt].
    assign so_idx = LAST - CW'(1) - cnt;

    always_ff @(posedge CLK) begin
        if (R) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            SI    <= 1'b0;
            SEN   <= 1'b0;
            LOAD  <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            DOUT  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    SI   <= 1'b0;
                    SEN  <= 1'b0;
                    LOAD <= 1'b0;
                    BUSY <= 1'b0;
                    DONE <= 1'b0;
                    if (START) begin
                        sreg            <= DIN;
                        SI              <= DIN[WIDTH-1];
                        SEN             <= 1'b1;
                        BUSY            <= 1'b1;
                        cnt             <= '0;
                        DOUT[WIDTH-1]   <= SO;
                        state           <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        // Last tail sample is the new word's first bit; drop it.
                        SEN   <= 1'b0;
                        SI    <= 1'b0;
                        LOAD  <= 1'b1;
                        state <= UPDATE;
                    end else begin
                        DOUT[so_idx] <= SO;
                        SI           <= sreg[WIDTH-2];
                        sreg         <= {sreg[WIDTH-2:0], sreg[WIDTH-1]};
                        cnt          <= cnt + CW'(1);
                    end
                end
                UPDATE: begin
                    LOAD  <= 1'b0;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= FIN;
                end
                FIN: begin
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dffn_chain_loader.sv
// Directed bench for dffn_chain_loader with behavioural negedge chain models (WIDTH 8 and 2).
module tb_dffn_chain_loader;

    logic       clk = 1'b0;
    logic       r   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       so, si, sen, load, busy, done;
    logic [7:0] dout;
    logic [7:0] chain;
    logic       pl_en = 1'b0;
    logic [7:0] pl_val = 8'h00;

    logic       start2 = 1'b0;
    logic [1:0] din2 = 2'b00;
    logic       so2, si2, sen2, load2, busy2, done2;
    logic [1:0] dout2;
    logic [1:0] chain2;
    logic       pl2_en = 1'b0;
    logic [1:0] pl2_val = 2'b00;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    dffn_chain_loader #(.WIDTH(8)) dut (
        .CLK(clk), .R(r), .START(start), .DIN(din), .SO(so),
        .SI(si), .SEN(sen), .LOAD(load), .BUSY(busy), .DONE(done), .DOUT(dout)
    );

    dffn_chain_loader #(.WIDTH(2)) dut2 (
        .CLK(clk), .R(r), .START(start2), .DIN(din2), .SO(so2),
        .SI(si2), .SEN(sen2), .LOAD(load2), .BUSY(busy2), .DONE(done2), .DOUT(dout2)
    );

    // Falling-edge chains: head fed by SI, tail drives SO.
    always @(negedge clk) begin
        if (pl_en) chain <= pl_val;
        else if (sen) chain <= {chain[6:0], si};
        if (pl2_en) chain2 <= pl2_val;
        else if (sen2) chain2 <= {chain2[0], si2};
    end
    assign so  = chain[7];
    assign so2 = chain2[1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] v, input logic [1:0] v2);
        pl_val = v; pl2_val = v2; pl_en = 1'b1; pl2_en = 1'b1;
        @(negedge clk);
        #1;
        pl_en = 1'b0; pl2_en = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b1; start = 1'b1; din = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({si, sen, load, busy, done, dout} !== 13'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got si=%b sen=%b load=%b busy=%b done=%b dout=%h, want all 0",
                         i, si, sen, load, busy, done, dout);
            end
            vectors++;
            if ({si2, sen2, load2, busy2, done2, dout2} !== 7'h0) begin
                errors++;
                $display("FAIL reset_outputs_w2 cyc%0d: got busy=%b sen=%b dout=%b, want 0", i, busy2, sen2, dout2);
            end
        end
        r = 1'b0;
        tick();
        start = 1'b0;
        vectors++;
        if ({busy, sen} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_accept: got busy=%b sen=%b, want 1 1", busy, sen);
        end
        repeat (10) tick();
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic       exp_sen, exp_si, exp_load, exp_busy, exp_done;
        preload(8'hA5, 2'b10);
        d = 8'h3C;
        din = d; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) tick();
            exp_sen  = (n <= 8);
            exp_si   = (n <= 8) ? d[8-n] : 1'b0;
            exp_load = (n == 9);
            exp_busy = (n <= 9);
            exp_done = (n == 10);
            vectors++;
            if ({sen, si, load, busy, done} !== {exp_sen, exp_si, exp_load, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL basic_cycle%0d: got sen=%b si=%b load=%b busy=%b done=%b, want %b %b %b %b %b",
                         n, sen, si, load, busy, done, exp_sen, exp_si, exp_load, exp_busy, exp_done);
            end
        end
        vectors++;
        if (dout !== 8'hA5) begin
            errors++;
            $display("FAIL basic_dout: got %h, want a5", dout);
        end
        vectors++;
        if (chain !== 8'h3C) begin
            errors++;
            $display("FAIL basic_chain: got %h, want 3c", chain);
        end
        tick();
        vectors++;
        if (dout !== 8'hA5) begin
            errors++;
            $display("FAIL basic_dout_hold: got %h, want a5", dout);
        end
    endtask

    task automatic test_back_to_back();
        int  gap;
        logic prev_busy;
        din = 8'hFF; start = 1'b1;
        tick();
        din = 8'h00;
        gap = -1;
        prev_busy = busy;
        for (int m = 1; m <= 20 && gap < 0; m++) begin
            tick();
            if (m == 9) begin
                vectors++;
                if (done !== 1'b1 || dout !== 8'h3C) begin
                    errors++;
                    $display("FAIL b2b_first_dout: got done=%b dout=%h, want 1 3c", done, dout);
                end
            end
            if (busy && !prev_busy) gap = m;
            prev_busy = busy;
        end
        start = 1'b0;
        vectors++;
        if (gap != 11) begin
            errors++;
            $display("FAIL b2b_accept_gap: got %0d, want 11", gap);
        end
        repeat (9) tick();
        vectors++;
        if (done !== 1'b1 || dout !== 8'hFF || chain !== 8'h00) begin
            errors++;
            $display("FAIL b2b_second: got done=%b dout=%h chain=%h, want 1 ff 00", done, dout, chain);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int loads = 0, dones = 0;
        din = 8'h66; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            if (n > 1) tick();
            loads += int'(load);
            dones += int'(done);
            start = (n == 3 || n == 10);
            din   = (n == 3 || n == 10) ? 8'h81 : 8'h66;
        end
        start = 1'b0;
        vectors++;
        if (loads != 1 || dones != 1) begin
            errors++;
            $display("FAIL ignored_strobes: got loads=%0d dones=%0d, want 1 1", loads, dones);
        end
        vectors++;
        if (chain !== 8'h66 || dout !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_result: got chain=%h dout=%h busy=%b, want 66 00 0", chain, dout, busy);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        din = 8'h33; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        r = 1'b1;
        tick();
        r = 1'b0;
        vectors++;
        if ({sen, busy, load, done, dout} !== 12'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got sen=%b busy=%b load=%b done=%b dout=%h, want 0",
                     sen, busy, load, done, dout);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            stray += int'(load) + int'(done) + int'(sen);
        end
        vectors++;
        if (stray != 0 || chain !== 8'h63) begin
            errors++;
            $display("FAIL midreset_idle: got stray=%0d chain=%h, want 0 63", stray, chain);
        end
        din = 8'h5A; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        vectors++;
        if (done !== 1'b1 || chain !== 8'h5A || dout !== 8'h63) begin
            errors++;
            $display("FAIL midreset_reload: got done=%b chain=%h dout=%h, want 1 5a 63", done, chain, dout);
        end
        tick();
    endtask

    task automatic test_width2();
        int   busy_cycles = 0;
        logic [1:0] si_seq = 2'b00;
        preload(8'h00, 2'b10);
        din2 = 2'b01; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            if (n > 1) tick();
            busy_cycles += int'(busy2);
            if (n <= 2) si_seq[2-n] = si2;
            if (n == 3) begin
                vectors++;
                if (load2 !== 1'b1 || sen2 !== 1'b0) begin
                    errors++;
                    $display("FAIL w2_update: got load=%b sen=%b, want 1 0", load2, sen2);
                end
            end
        end
        vectors++;
        if (done2 !== 1'b1 || dout2 !== 2'b10 || chain2 !== 2'b01) begin
            errors++;
            $display("FAIL w2_result: got done=%b dout=%b chain=%b, want 1 10 01", done2, dout2, chain2);
        end
        vectors++;
        if (busy_cycles != 3 || si_seq !== 2'b01) begin
            errors++;
            $display("FAIL w2_timing: got busy_cycles=%0d si_seq=%b, want 3 01", busy_cycles, si_seq);
        end
        tick();
    endtask

    initial begin
        preload(8'h00, 2'b00);
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_width2();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
